// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: writeback vs. long-latency unit,
// with a pending-destination scoreboard that stalls decode on hazards.
module regfile_write_arbiter #(
  parameter int MAX_WAIT        = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_RegWrite,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        wb_stall,
  input  logic        llu_valid,
  input  logic [4:0]  llu_rd,
  input  logic [31:0] llu_data,
  output logic        llu_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic [4:0]  dec_rd,
  input  logic        dec_valid,
  output logic        sb_stall,
  output logic        RegWrite,
  output logic [4:0]  write_id,
  output logic [31:0] write_data
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FORCE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [31:0]     busy_q, busy_d;
  logic [OW-1:0]   out_q, out_d;

  logic wb_req;
  logic llu_gnt;
  logic xfer;
  logic issue_acc;
  logic out_dec;
  logic hazard;

  assign wb_req = wb_RegWrite && (wb_rd != 5'd0);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    llu_gnt    = 1'b0;
    wb_stall   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (llu_valid && wb_req) begin
          state_d    = (MAX_WAIT == 1) ? FORCE : WAIT;
          wait_cnt_d = CW'(1);
        end else begin
          llu_gnt = llu_valid;
        end
      end
      WAIT: begin
        if (!llu_valid) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else if (!wb_req) begin
          llu_gnt    = 1'b1;
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
          if (wait_cnt_d == CW'(MAX_WAIT))
            state_d = FORCE;
        end
      end
      FORCE: begin
        state_d    = IDLE;
        wait_cnt_d = '0;
        // A withdrawn LLU result leaves the port to writeback
        if (llu_valid) begin
          llu_gnt  = 1'b1;
          wb_stall = wb_req;
        end
      end
      default: begin
        state_d    = IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  assign llu_ready  = llu_gnt;
  assign xfer       = llu_valid && llu_gnt;
  assign RegWrite   = llu_gnt ? (llu_rd != 5'd0) : wb_req;
  assign write_id   = llu_gnt ? llu_rd : wb_rd;
  assign write_data = llu_gnt ? llu_data : wb_data;

  assign hazard = dec_valid &&
                  (busy_q[dec_rs1] || busy_q[dec_rs2] || busy_q[dec_rd]);

  assign sb_stall = hazard ||
                    (issue_valid && (out_q == OW'(MAX_OUTSTANDING)));

  assign issue_acc = issue_valid && !sb_stall && (issue_rd != 5'd0);
  assign out_dec   = xfer && (out_q != '0);

  always_comb begin
    busy_d = busy_q;
    if (xfer)
      busy_d[llu_rd] = 1'b0;
    if (issue_acc)
      busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
    out_d = out_q;
    if (issue_acc && !out_dec)
      out_d = out_q + 1'b1;
    else if (!issue_acc && out_dec)
      out_d = out_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      busy_q     <= '0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      busy_q     <= busy_d;
      out_q      <= out_d;
    end
  end

  a_xfer_busy: assert property (
    @(posedge clk) disable iff (rst) xfer |-> busy_q[llu_rd]);

endmodule
